// File: rtl/mileage_pkg.sv
// Shared definitions for the mileage accumulator: FSM encoding, record
// width, default saturation ceiling and the BCD digit increment helper.
package mileage_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_STOP = 2'd1,
    ST_MOVE = 2'd2
  } state_e;

  localparam int RECORD_W           = 27;
  localparam int DEFAULT_MAX_RECORD = 99_999_999;

  // Next value of a single decimal digit, wrapping 9 -> 0.
  function automatic logic [3:0] bcd_inc(input logic [3:0] d);
    logic [3:0] r;
    if (d >= 4'd9) begin
      r = 4'd0;
    end else begin
      r = d + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mileage_accumulator_bcd_digit_cnt.sv
// One decimal digit of the ripple BCD mileage counter. Only built when
// MILEAGE_BCD_EN is defined; the default build has no BCD logic at all.
`ifdef MILEAGE_BCD_EN
module bcd_digit_cnt
  import mileage_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc_in,
  output logic [3:0] digit,
  output logic [3:0] digit_unused_guard,
  output logic       carry_out
);

  logic [3:0] digit_r;

  // Digit register: advances by one (wrapping 9 -> 0) when incremented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_r <= 4'd0;
    end else if (inc_in) begin
      digit_r <= bcd_inc(digit_r);
    end else begin
      digit_r <= digit_r;
    end
  end

  assign digit              = digit_r;
  assign digit_unused_guard = digit_r;
  assign carry_out          = inc_in && (digit_r == 4'd9);

endmodule
`endif

// File: rtl/mileage_accumulator.sv
// Mileage accumulator: OFF/STOP/MOVE vehicle FSM, distance prescaler,
// saturating 27-bit record and one-cycle unit pulse.
// Optional feature macro: MILEAGE_BCD_EN (maintains record_bcd as an
// 8-digit BCD counter; otherwise record_bcd is tied to zero).
module mileage_accumulator
  import mileage_pkg::*;
#(
  parameter int TICK_DIV   = 100_000_000,
  parameter int MAX_RECORD = DEFAULT_MAX_RECORD
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                power_now,
  input  logic                throttle,
  input  logic                brake,
  output logic [RECORD_W-1:0] record,
  output logic [31:0]         record_bcd,
  output logic                unit_tick,
  output logic                moving,
  output logic                sat
);

  localparam int                  PRESC_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [RECORD_W-1:0] REC_MAX    = RECORD_W'(MAX_RECORD);

  state_e              state_r;
  state_e              state_nxt_s;
  logic [PRESC_W-1:0]  prescaler_r;
  logic [PRESC_W-1:0]  prescaler_nxt_s;
  logic [RECORD_W-1:0] record_r;
  logic [RECORD_W-1:0] record_nxt_s;
  logic                unit_tick_r;
  logic                moving_r;
  logic                sat_r;
  logic                stay_move_s;
  logic                at_max_s;
  logic                inc_s;

  // Next-state logic: loss of power overrides everything, brake beats throttle.
  always_comb begin
    state_nxt_s = state_r;
    if (!power_now) begin
      state_nxt_s = ST_OFF;
    end else begin
      case (state_r)
        ST_OFF:  state_nxt_s = ST_STOP;
        ST_STOP: begin
          if (throttle && !brake) begin
            state_nxt_s = ST_MOVE;
          end else begin
            state_nxt_s = ST_STOP;
          end
        end
        ST_MOVE: begin
          if (brake || !throttle) begin
            state_nxt_s = ST_STOP;
          end else begin
            state_nxt_s = ST_MOVE;
          end
        end
        default: state_nxt_s = ST_OFF;
      endcase
    end
  end

  // Prescaler and increment decision: leaving MOVE drops the partial unit
  // and wins over a coincident terminal count; saturation parks the count.
  always_comb begin
    stay_move_s     = (state_r == ST_MOVE) && (state_nxt_s == ST_MOVE);
    at_max_s        = (record_r == REC_MAX);
    inc_s           = 1'b0;
    prescaler_nxt_s = prescaler_r;
    if (!stay_move_s || at_max_s) begin
      prescaler_nxt_s = '0;
    end else if (prescaler_r == PRESC_LAST) begin
      prescaler_nxt_s = '0;
      inc_s           = 1'b1;
    end else begin
      prescaler_nxt_s = prescaler_r + PRESC_W'(1);
    end
    if (inc_s) begin
      record_nxt_s = record_r + RECORD_W'(1);
    end else begin
      record_nxt_s = record_r;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_OFF;
      prescaler_r <= '0;
      record_r    <= '0;
      unit_tick_r <= 1'b0;
      moving_r    <= 1'b0;
      sat_r       <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      prescaler_r <= prescaler_nxt_s;
      record_r    <= record_nxt_s;
      unit_tick_r <= inc_s;
      moving_r    <= (state_nxt_s == ST_MOVE);
      sat_r       <= sat_r | (record_nxt_s == REC_MAX);
    end
  end

  assign record    = record_r;
  assign unit_tick = unit_tick_r;
  assign moving    = moving_r;
  assign sat       = sat_r;

`ifdef MILEAGE_BCD_EN
  logic [8:0]  carry_s;
  logic [31:0] guard_s;

  assign carry_s[0] = inc_s;

  for (genvar g = 0; g < 8; g++) begin : g_digit
    bcd_digit_cnt u_digit (
      .clk                (clk),
      .rst_n              (rst_n),
      .inc_in             (carry_s[g]),
      .digit              (record_bcd[4*g +: 4]),
      .digit_unused_guard (guard_s[4*g +: 4]),
      .carry_out          (carry_s[g+1])
    );
  end
`else
  assign record_bcd = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_mileage_accumulator.sv
// Directed self-checking bench for mileage_accumulator. Two instances:
// dut (TICK_DIV=4, default ceiling) and dut_s (TICK_DIV=2, MAX_RECORD=10).
module tb_mileage_accumulator;

  logic        clk = 1'b0;
  logic        rst_n, power_now, throttle, brake;
  logic [26:0] record;
  logic [31:0] record_bcd;
  logic        unit_tick, moving, sat;

  logic        rst_s_n, power_s, throttle_s, brake_s;
  logic [26:0] record_s;
  logic [31:0] record_bcd_s;
  logic        unit_tick_s, moving_s, sat_s;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mileage_accumulator #(.TICK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .power_now(power_now), .throttle(throttle),
    .brake(brake), .record(record), .record_bcd(record_bcd),
    .unit_tick(unit_tick), .moving(moving), .sat(sat)
  );

  mileage_accumulator #(.TICK_DIV(2), .MAX_RECORD(10)) dut_s (
    .clk(clk), .rst_n(rst_s_n), .power_now(power_s), .throttle(throttle_s),
    .brake(brake_s), .record(record_s), .record_bcd(record_bcd_s),
    .unit_tick(unit_tick_s), .moving(moving_s), .sat(sat_s)
  );

  // Advance one clock and sample 1 ns after the rising edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rst_s_n = 1'b0;
    power_now = 1'b0; throttle = 1'b0; brake = 1'b0;
    power_s = 1'b0; throttle_s = 1'b0; brake_s = 1'b0;
    tick(2);
    tests++; if (record !== 27'd0) begin fails++; $display("FAIL reset_record: got %0d expected 0", record); end
    tests++; if (record_bcd !== 32'h0) begin fails++; $display("FAIL reset_bcd: got %h expected 0", record_bcd); end
    tests++; if ({unit_tick, moving, sat} !== 3'b000) begin fails++; $display("FAIL reset_flags: got %b expected 000", {unit_tick, moving, sat}); end
    tests++; if ({record_s, sat_s} !== 28'd0) begin fails++; $display("FAIL reset_dut_s: got %0d/%0d expected 0/0", record_s, sat_s); end
    rst_n = 1'b1; rst_s_n = 1'b1;
    tick(1);
  endtask

  // Test 1: steady driving, five units in 20 cycles, pulses 4 apart.
  task automatic test_drive;
    int pulses;
    int bad_spacing;
    logic [31:0] exp_bcd;
    pulses = 0; bad_spacing = 0;
    power_now = 1'b1;
    tick(1);
    tests++; if (moving !== 1'b0) begin fails++; $display("FAIL stop_moving: got %0d expected 0", moving); end
    throttle = 1'b1;
    tick(1);
    tests++; if (moving !== 1'b1) begin fails++; $display("FAIL move_moving: got %0d expected 1", moving); end
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      if (unit_tick === 1'b1) begin
        pulses++;
        if ((k % 4) != 0) bad_spacing++;
      end
    end
`ifdef MILEAGE_BCD_EN
    exp_bcd = 32'h0000_0005;
`else
    exp_bcd = 32'h0000_0000;
`endif
    tests++; if (record !== 27'd5) begin fails++; $display("FAIL drive_record: got %0d expected 5", record); end
    tests++; if (pulses != 5) begin fails++; $display("FAIL drive_pulses: got %0d expected 5", pulses); end
    tests++; if (bad_spacing != 0) begin fails++; $display("FAIL drive_spacing: got %0d off-grid pulses expected 0", bad_spacing); end
    tests++; if (sat !== 1'b0) begin fails++; $display("FAIL drive_sat: got %0d expected 0", sat); end
    tests++; if (record_bcd !== exp_bcd) begin fails++; $display("FAIL drive_bcd: got %h expected %h", record_bcd, exp_bcd); end
  endtask

  // Test 2: one-cycle brake at prescaler 2 loses the partial unit.
  task automatic test_brake;
    tick(2);
    brake = 1'b1;
    tick(1);
    tests++; if (moving !== 1'b0) begin fails++; $display("FAIL brake_moving: got %0d expected 0", moving); end
    tests++; if (record !== 27'd5) begin fails++; $display("FAIL brake_record: got %0d expected 5", record); end
    brake = 1'b0;
    tick(1);
    tests++; if (moving !== 1'b1) begin fails++; $display("FAIL resume_moving: got %0d expected 1", moving); end
    tick(3);
    tests++; if (record !== 27'd5) begin fails++; $display("FAIL resume_early: got %0d expected 5", record); end
    tick(1);
    tests++; if (record !== 27'd6) begin fails++; $display("FAIL resume_record: got %0d expected 6", record); end
    tests++; if (unit_tick !== 1'b1) begin fails++; $display("FAIL resume_tick: got %0d expected 1", unit_tick); end
  endtask

  // Test 3: power loss coincident with terminal count: no increment.
  task automatic test_power_loss;
    tick(3);
    power_now = 1'b0;
    tick(1);
    tests++; if (record !== 27'd6) begin fails++; $display("FAIL pwr_record: got %0d expected 6", record); end
    tests++; if ({moving, unit_tick} !== 2'b00) begin fails++; $display("FAIL pwr_flags: got %b expected 00", {moving, unit_tick}); end
    power_now = 1'b1;
    tick(2);
    tests++; if (moving !== 1'b1) begin fails++; $display("FAIL repower_moving: got %0d expected 1", moving); end
    tick(4);
    tests++; if (record !== 27'd7) begin fails++; $display("FAIL repower_record: got %0d expected 7", record); end
    tests++; if (unit_tick !== 1'b1) begin fails++; $display("FAIL repower_tick: got %0d expected 1", unit_tick); end
  endtask

  // Test 5: asynchronous reset mid-cycle clears outputs without a clock edge.
  task automatic test_async_reset;
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if (record !== 27'd0) begin fails++; $display("FAIL async_record: got %0d expected 0", record); end
    tests++; if ({unit_tick, moving, sat} !== 3'b000) begin fails++; $display("FAIL async_flags: got %b expected 000", {unit_tick, moving, sat}); end
    tests++; if (record_bcd !== 32'h0) begin fails++; $display("FAIL async_bcd: got %h expected 0", record_bcd); end
    power_now = 1'b0; throttle = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);
  endtask

  // Test 4: saturation at MAX_RECORD=10 with TICK_DIV=2.
  task automatic test_saturation;
    int pulses;
    pulses = 0;
    power_s = 1'b1; throttle_s = 1'b1;
    tick(2);
    tests++; if (sat_s !== 1'b0) begin fails++; $display("FAIL sat_early: got %0d expected 0", sat_s); end
    for (int k = 1; k <= 40; k++) begin
      tick(1);
      if (unit_tick_s === 1'b1) pulses++;
    end
    tests++; if (record_s !== 27'd10) begin fails++; $display("FAIL sat_record: got %0d expected 10", record_s); end
    tests++; if (sat_s !== 1'b1) begin fails++; $display("FAIL sat_flag: got %0d expected 1", sat_s); end
    tests++; if (pulses != 10) begin fails++; $display("FAIL sat_pulses: got %0d expected 10", pulses); end
    tests++; if (moving_s !== 1'b1) begin fails++; $display("FAIL sat_moving: got %0d expected 1", moving_s); end
  endtask

  // Test 6: BCD view of record around the 1099 -> 1100 carry ripple.
  task automatic test_bcd;
    int guard;
    logic [31:0] exp_a, exp_b;
`ifdef MILEAGE_BCD_EN
    exp_a = 32'h0000_1099; exp_b = 32'h0000_1100;
`else
    exp_a = 32'h0000_0000; exp_b = 32'h0000_0000;
`endif
    power_now = 1'b1; throttle = 1'b1;
    guard = 0;
    while (record !== 27'd1099 && guard < 6000) begin
      tick(1);
      guard++;
    end
    tests++; if (record !== 27'd1099) begin fails++; $display("FAIL bcd_reach: got %0d expected 1099 (cycle budget)", record); end
    tests++; if (record_bcd !== exp_a) begin fails++; $display("FAIL bcd_1099: got %h expected %h", record_bcd, exp_a); end
    tick(3);
    tests++; if (record !== 27'd1099) begin fails++; $display("FAIL bcd_hold: got %0d expected 1099", record); end
    tick(1);
    tests++; if (record !== 27'd1100) begin fails++; $display("FAIL bcd_rec1100: got %0d expected 1100", record); end
    tests++; if (record_bcd !== exp_b) begin fails++; $display("FAIL bcd_1100: got %h expected %h", record_bcd, exp_b); end
  endtask

  initial begin
    test_reset();
    test_drive();
    test_brake();
    test_power_loss();
    test_async_reset();
    test_saturation();
    test_bcd();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
